// File: rtl/note_tone_generator_if.sv
// rtl/note_tone_generator_if.sv - note stream in, buzzer/status out
interface note_tone_generator_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  enable;
    logic                  note_valid;
    logic [DATA_WIDTH-1:0] note_in;
    logic                  buzzer;
    logic                  playing;
    logic                  resting;
    logic                  note_change;
    logic [DATA_WIDTH-1:0] cur_code;

    modport master (
        output enable, note_valid, note_in,
        input  buzzer, playing, resting, note_change, cur_code
    );

    modport slave (
        input  enable, note_valid, note_in,
        output buzzer, playing, resting, note_change, cur_code
    );
endinterface

// File: rtl/note_tone_generator.sv
// rtl/note_tone_generator.sv - decodes note words into a buzzer square wave
// and tracks idle/tone/rest playback with a note-change pulse.
module note_tone_generator #(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 20,
    parameter int DIV_SHIFT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    note_tone_generator_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_TONE, S_REST} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  counter_q, counter_d;
    logic [CNT_WIDTH-1:0]  half_q, half_d;
    logic                  buzzer_q, buzzer_d;
    logic                  nc_q, nc_d;
    logic [DATA_WIDTH-1:0] code_q, code_d;
    logic                  capture;
    logic                  in_note;
    logic [CNT_WIDTH-1:0]  in_half;

    function automatic logic one_hot(input logic [6:0] bits);
        return (bits != 7'd0) && ((bits & (bits - 7'd1)) == 7'd0);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] half_of(input logic [8:0] w);
        logic [CNT_WIDTH-1:0] base;
        logic [CNT_WIDTH-1:0] adj;
        logic [CNT_WIDTH-1:0] shifted;
        case (w[8:2])
            7'b0000001: base = CNT_WIDTH'(191110);
            7'b0000010: base = CNT_WIDTH'(170265);
            7'b0000100: base = CNT_WIDTH'(151685);
            7'b0001000: base = CNT_WIDTH'(143172);
            7'b0010000: base = CNT_WIDTH'(127551);
            7'b0100000: base = CNT_WIDTH'(113636);
            7'b1000000: base = CNT_WIDTH'(101239);
            default:    base = '0;
        endcase
        case (w[1:0])
            2'b01:   adj = base >> 1;
            2'b10:   adj = base << 1;
            default: adj = base;
        endcase
        shifted = adj >> DIV_SHIFT;
        return (shifted < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : shifted;
    endfunction

    assign in_note = one_hot(bus.note_in[8:2]);
    assign in_half = half_of(bus.note_in[8:0]);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        half_d    = half_q;
        buzzer_d  = buzzer_q;
        code_d    = code_q;
        nc_d      = 1'b0;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable && bus.note_valid) begin
                    capture = 1'b1;
                end
            end
            default: begin
                if (!bus.enable || !bus.note_valid) begin
                    state_d   = S_IDLE;
                    counter_d = '0;
                    buzzer_d  = 1'b0;
                end else if (bus.note_in[8:0] != code_q[8:0]) begin
                    capture = 1'b1;
                end else if (state_q == S_TONE) begin
                    if (counter_q == half_q - CNT_WIDTH'(1)) begin
                        counter_d = '0;
                        buzzer_d  = ~buzzer_q;
                    end else begin
                        counter_d = counter_q + CNT_WIDTH'(1);
                    end
                end
            end
        endcase

        // A capture restarts the waveform even if a half-period expires on the same edge.
        if (capture) begin
            state_d   = in_note ? S_TONE : S_REST;
            code_d    = bus.note_in;
            half_d    = in_half;
            counter_d = '0;
            buzzer_d  = 1'b0;
            nc_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            half_q    <= CNT_WIDTH'(2);
            buzzer_q  <= 1'b0;
            code_q    <= '0;
            nc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            half_q    <= half_d;
            buzzer_q  <= buzzer_d;
            code_q    <= code_d;
            nc_q      <= nc_d;
        end
    end

    assign bus.buzzer      = buzzer_q;
    assign bus.playing     = (state_q == S_TONE);
    assign bus.resting     = (state_q == S_REST);
    assign bus.note_change = nc_q;
    assign bus.cur_code    = code_q;
endmodule

// File: tb/tb_note_tone_generator.sv
// tb/tb_note_tone_generator.sv - randomized bench with a period-arithmetic reference model
module tb_note_tone_generator;
    localparam int DW = 10;
    localparam int CW = 20;
    localparam int DS = 10;

    localparam logic [9:0] LA_MID  = 10'b0010000000;
    localparam logic [9:0] LA_HIGH = 10'b0010000001;
    localparam logic [9:0] LA_LOW  = 10'b0010000010;
    localparam logic [9:0] DO_MID  = 10'b0000000100;
    localparam logic [9:0] SOL_MID = 10'b0001000000;

    logic clk = 1'b0;
    logic rst;

    note_tone_generator_if #(.DATA_WIDTH(DW)) ifc ();

    note_tone_generator #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .DIV_SHIFT (DS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 tone, 2 rest; m_t = edges since capture.
    int         m_mode;
    logic [9:0] m_code;
    int         m_t;
    int         m_half;
    bit         m_nc;
    int         base_tab[7] = '{191110, 170265, 151685, 143172, 127551, 113636, 101239};

    function automatic int ref_half(logic [9:0] w);
        int b = 0;
        for (int i = 0; i < 7; i++) if (w[2+i]) b = base_tab[i];
        if (w[1:0] == 2'b01) b = b / 2;
        else if (w[1:0] == 2'b10) b = b * 2;
        b = b / (1 << DS);
        if (b < 2) b = 2;
        return b;
    endfunction

    function automatic bit ref_is_note(logic [9:0] w);
        return $countones(w[8:2]) == 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_code = '0; m_t = 0; m_half = 0; m_nc = 0;
    endtask

    task automatic model_capture(logic [9:0] w);
        m_code = w;
        m_mode = ref_is_note(w) ? 1 : 2;
        m_t    = 0;
        m_half = ref_half(w);
        m_nc   = 1;
    endtask

    task automatic model_edge();
        m_nc = 0;
        if (m_mode == 0) begin
            if (ifc.enable && ifc.note_valid) model_capture(ifc.note_in);
        end else if (!ifc.enable || !ifc.note_valid) begin
            m_mode = 0;
        end else if (ifc.note_in[8:0] != m_code[8:0]) begin
            model_capture(ifc.note_in);
        end else begin
            m_t++;
        end
    endtask

    function automatic logic [13:0] exp_vec();
        logic buz;
        buz = (m_mode == 1) ? (((m_t / m_half) % 2) == 1) : 1'b0;
        return {buz, m_mode == 1, m_mode == 2, m_nc, m_code};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {ifc.buzzer, ifc.playing, ifc.resting, ifc.note_change, ifc.cur_code};
    endfunction

    task automatic drive(bit en, bit v, logic [9:0] w);
        ifc.enable = en; ifc.note_valid = v; ifc.note_in = w;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec() !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", obs_vec());
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, LA_MID);
            tick();
            n_checks++;
            if (obs_vec() !== 14'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset cycle %0d: got %h expected 0", i, obs_vec());
            end
        end
    endtask

    task automatic test_la_middle();
        int pulses = 0;
        int rise = -1;
        for (int i = 0; i < 400; i++) begin
            drive(1, 1, LA_MID);
            tick();
            if (ifc.note_change) pulses++;
            if (ifc.buzzer && rise < 0) rise = i;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL la_mid cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (rise !== 110) begin
            n_fail++;
            $display("FAIL la_mid_first_rise: got %0d expected 110", rise);
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL la_mid_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_octaves();
        int rise_hi = -1;
        int rise_lo = -1;
        for (int i = 0; i < 200; i++) begin
            drive(1, 1, LA_HIGH);
            tick();
            if (ifc.buzzer && rise_hi < 0) rise_hi = i;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL la_high cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 500; i++) begin
            drive(1, 1, LA_LOW);
            tick();
            if (ifc.buzzer && rise_lo < 0) rise_lo = i;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL la_low cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (rise_hi !== 55) begin
            n_fail++;
            $display("FAIL la_high_first_rise: got %0d expected 55", rise_hi);
        end
        n_checks++;
        if (rise_lo !== 221) begin
            n_fail++;
            $display("FAIL la_low_first_rise: got %0d expected 221", rise_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] seq[4] = '{DO_MID, DO_MID, SOL_MID, SOL_MID};
        int pulses = 0;
        int rise_sol = -1;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 150; i++) begin
                drive(1, 1, seq[s]);
                tick();
                if (ifc.note_change) pulses++;
                if (s == 2 && ifc.buzzer && rise_sol < 0) rise_sol = i;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL repeat seg %0d cycle %0d: got %h expected %h", s, i, obs_vec(), exp_vec());
                end
            end
        end
        n_checks++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL repeat_pulses: got %0d expected 2", pulses);
        end
        n_checks++;
        if (rise_sol !== 124) begin
            n_fail++;
            $display("FAIL sol_first_rise: got %0d expected 124", rise_sol);
        end
    endtask

    task automatic test_rest();
        logic [9:0] words[3] = '{10'b0000000000, 10'b0001100000, 10'b1000000011};
        int buz_high = 0;
        int rest_cyc = 0;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 60; i++) begin
                drive(1, 1, words[s]);
                tick();
                if (ifc.buzzer || ifc.playing) buz_high++;
                if (ifc.resting) rest_cyc++;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rest seg %0d cycle %0d: got %h expected %h", s, i, obs_vec(), exp_vec());
                end
            end
        end
        n_checks++;
        if (buz_high !== 0 || rest_cyc !== 180) begin
            n_fail++;
            $display("FAIL rest_summary: got buzzer/playing %0d resting %0d expected 0 and 180", buz_high, rest_cyc);
        end
    endtask

    task automatic test_drop();
        int pulses = 0;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < ((s % 2 == 1) ? 1 : 150); i++) begin
                if (s == 1) drive(1, 0, LA_MID);
                else if (s == 3) drive(0, 1, LA_MID);
                else drive(1, 1, LA_MID);
                tick();
                if (ifc.note_change) pulses++;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL drop seg %0d cycle %0d: got %h expected %h", s, i, obs_vec(), exp_vec());
                end
            end
        end
        n_checks++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL drop_pulses: got %0d expected 3", pulses);
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            drive(1, 1, LA_MID);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (ifc.buzzer) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL pre_reset_buzzer: got 0 expected 1 within 300 cycles");
        end
        #2;
        rst = 1'b1;
        drive(1, 0, LA_MID);
        #1;
        n_checks++;
        if ({ifc.buzzer, ifc.playing, ifc.cur_code} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", {ifc.buzzer, ifc.playing, ifc.cur_code});
        end
        model_reset();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive(1, i >= 10, LA_MID);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] w;
        int hold;
        int r;
        for (int seg = 0; seg < 25; seg++) begin
            r = $urandom_range(0, 9);
            if (r < 7) w = 10'(1 << (r + 2));
            else if (r == 7) w = '0;
            else if (r == 8) w = 10'b0000101000;
            else w = 10'($urandom);
            w[1:0] = 2'($urandom_range(0, 3));
            w[9]   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 400);
            for (int i = 0; i < hold; i++) begin
                r = $urandom_range(0, 99);
                drive(r != 0, r != 1, w);
                tick();
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random seg %0d cycle %0d word %b: got %h expected %h", seg, i, w, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_la_middle();
        test_octaves();
        test_back_to_back();
        test_rest();
        test_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/note_tone_generator.md
Name: note_tone_generator

Overview:
- Downstream consumer of the internal/user music memory stages.
- Takes each 10-bit note word and its ready flag, decodes note and octave, and drives a buzzer square wave at the note's pitch.
- Tracks playback state (idle / tone / rest) and flags every note change so the display/LED stage can follow the music.

Parameters:
- DATA_WIDTH, 10, note word width; must match the memory stage.
- CNT_WIDTH, 20, width of the half-period counter.
- DIV_SHIFT, 0, right-shift applied to every half-period; non-zero only for simulation speed-up.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  playback enable; low forces IDLE.
- note_valid  input  1  driven from the memory stage's output_ready.
- note_in  input  DATA_WIDTH  note word from the memory stage's data_out.
- buzzer  output  1  square-wave audio output.
- playing  output  1  high while in TONE.
- resting  output  1  high while in REST.
- note_change  output  1  one-cycle pulse on every accepted code change.
- cur_code  output  DATA_WIDTH  registered copy of the note word being played.

Behaviour:
- Reset is asynchronous. On rst: state=IDLE, buzzer=0, playing=0, resting=0, note_change=0, cur_code=0, counter=0.
- Note word decode:
  - bits[8:2] one-hot: do, re, mi, fa, sol, la, si (bit2=do … bit8=si).
  - bits[1:0] octave: 00 middle, 01 high, 10 low, 11 treated as middle.
  - bit9 ignored.
- Note bits all zero, or more than one bit set, decode as a rest.
- Middle-octave half periods, fixed constants in clock cycles: do 191110, re 170265, mi 151685, fa 143172, sol 127551, la 113636, si 101239.
- Octave adjustment: high = constant>>1; low = constant<<1.
- DIV_SHIFT is then applied as a right-shift. The result is clamped to a minimum of 2.
- Arithmetic: all values are unsigned in CNT_WIDTH bits. Low si (202478) fits; low do (382220) fits.
- State machine, evaluated each rising edge:
  - IDLE: if enable && note_valid, capture note_in. Go to TONE (valid note) or REST (rest code). Set note_change=1.
  - TONE/REST, enable=0 or note_valid=0: go to IDLE next edge. buzzer=0, counter=0, cur_code held, no note_change.
  - TONE/REST, note_valid=1 and note_in[8:0] differs from cur_code[8:0]: capture note_in and re-enter TONE/REST per decode. counter=0, buzzer=0, note_change=1.
  - TONE/REST, note_valid=1 and note_in[8:0] unchanged: continue; no restart, no pulse. Repeated identical words therefore sound as one sustained tone.
- Tone timing: on the capture edge, counter=0 and buzzer=0. Each later edge in TONE, counter increments. When counter==half-1, counter=0 and buzzer toggles.
  - First buzzer rise occurs exactly `half` cycles after the capture edge.
  - Full period is 2*half.
- REST: buzzer held 0, counter held 0, resting=1.
- Output validity: playing and resting are registered and valid on the edge the state is entered. note_change is high for exactly the cycle following the capture edge.
- Simultaneous events:
  - rst dominates everything.
  - enable=0 dominates note_valid.
  - A code change on the same edge a half-period expires takes the new note; no toggle occurs.
- Reset mid-tone: buzzer drops to 0 immediately (asynchronous), with no glitch on the next clock.

Test Plan:
- Test 1, DIV_SHIFT=10, middle la (10'b0010000000), held valid: after capture, buzzer rises after 110 cycles and toggles every 110 cycles; playing=1; note_change pulses once.
- Test 2, DIV_SHIFT=10, note word 10'b0010000001 (high la): half period 55; low la (…10): half period 221.
- Test 3, feed sequence do, do, sol, sol: note_change pulses exactly twice; the do tone is not restarted by the second word; counter resets on the switch to sol.
- Test 4, rest and illegal codes: note_in=0 or 10'b0001100000 with note_valid=1 → resting=1, buzzer=0 throughout, playing=0.
- Test 5, drop note_valid (or enable) mid-tone: IDLE next edge, buzzer=0, playing=0. Re-asserting with the same code re-captures and pulses note_change.
- Test 6, assert rst asynchronously mid-period with buzzer=1: buzzer/playing/cur_code go 0 before the next clk edge; after release, the block stays IDLE until note_valid.
